spi_mem_master: RTL and testbench
=================================

Name: spi_mem_master

Overview:
Parametrised next-generation SPI master for the serial memory path. It takes single-word read/write requests over a valid/ready handshake and checks the address against DEPTH. It serialises a framed op/addr/data transaction on cs/sclk/mosi, using a real divided serial clock and selectable bit order. It waits for slave ready/op_done with a timeout, then returns data and an error code on a one-cycle response pulse. It sits between the host-side controller and the spi memory slave in top.

Parameters:
ADDR_W, 8, address field width in bits
DATA_W, 8, data field width in bits
DEPTH, 32, valid addresses are 0..DEPTH-1; DEPTH <= 2**ADDR_W
CLK_DIV, 1, sclk half-period in clk cycles (>=1); one bit = 2*CLK_DIV cycles
LSB_FIRST, 1, 1: each field sent/received LSB first; 0: MSB first
TIMEOUT, 255, max clk cycles spent waiting for ready/op_done (>=1)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  master idle and able to accept
req_wr  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  target address
req_din  input  DATA_W  write data
rsp_valid  output  1  one-cycle pulse: transaction finished
rsp_err  output  2  0 ok, 1 address out of range, 2 timeout
rsp_dout  output  DATA_W  read data
cs  output  1  chip select, active-low
sclk  output  1  serial clock, idles low (mode 0)
mosi  output  1  serial data to slave
miso  input  1  serial data from slave
ready  input  1  slave read data available
op_done  input  1  slave write committed

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_err=0, rsp_dout=0, cs=1, sclk=0, mosi=0. The FSM enters IDLE; req_ready is 1 from the first cycle after rst deasserts.
- States: IDLE, CHECK, TX, WAIT_DONE, WAIT_RDY, RX, RESP.
- IDLE: req_ready=1. A request is accepted when req_valid&req_ready at an edge; wr/addr/din are latched. The FSM goes to CHECK and req_ready drops the same edge.
- CHECK (1 cycle):
  - If addr >= DEPTH: go to RESP with rsp_err=1; cs is never asserted.
  - Otherwise: cs<=0, mosi<=bit0 of the frame, go to TX.
- Frame: op bit (1 write / 0 read), then addr (ADDR_W bits), then for writes only data (DATA_W bits). Each field is LSB-first if LSB_FIRST else MSB-first. Frame length is 1+ADDR_W+DATA_W bits for a write and 1+ADDR_W for a read.
- Bit timing: each bit holds sclk low for CLK_DIV cycles, then high for CLK_DIV cycles. mosi changes only on sclk falling edges (and at frame start). cs is low for exactly 2*CLK_DIV*frame_len cycles, then cs<=1, sclk<=0, mosi<=0.
- Write: TX -> WAIT_DONE. On op_done high, go to RESP with err=0.
- Read: TX -> WAIT_RDY. On ready high, cs<=0 and go to RX. RX generates DATA_W sclk periods and samples miso on each sclk rising edge into a shift register in the LSB_FIRST order. After the last high phase: cs<=1, rsp_dout<=assembled word, go to RESP with err=0.
- Timeout:
  - A wait counter clears on entry to WAIT_DONE/WAIT_RDY and increments each cycle in those states.
  - When it reaches TIMEOUT without the handshake, go to RESP with err=2; cs stays high.
  - If the handshake and the final count occur in the same cycle, the handshake wins.
- RESP (1 cycle): rsp_valid=1 with rsp_err. rsp_dout changes only on a successful read and otherwise holds its value. The FSM then returns to IDLE.
- ready/op_done outside their wait state are ignored. req_valid while busy is ignored (req_ready=0).
- Reset mid-operation: at the next edge cs=1, sclk=0, mosi=0, no rsp_valid, FSM to IDLE; latched request discarded.
- Latency, write, CLK_DIV=1, 8/8: accept T0, CHECK T1, cs low T2..T35. rsp_valid is asserted the cycle after op_done is sampled.

Test Plan:
- Config for all scenarios: ADDR_W=8, DATA_W=8, DEPTH=32, CLK_DIV=2.
- Write, LSB_FIRST=1, addr=0x05, din=0xA3 -> cs low 68 cycles; mosi bit sequence 1,1,0,1,0,0,0,0,0,1,1,0,0,0,1,0,1, each bit held 4 cycles. After op_done pulse -> rsp_valid one cycle, rsp_err=0.
- Read addr=0x1F, slave asserts ready after 10 cycles, then drives 0x5C LSB-first -> 9-bit frame (36 cycles cs low), RX 8 sclk periods, rsp_dout=0x5C, rsp_err=0.
- Out-of-range addr=0x20 (write and read) -> cs stays 1 throughout, sclk never toggles, rsp_valid at T2 with rsp_err=1, rsp_dout unchanged.
- TIMEOUT=20, read with ready never asserted -> rsp_err=2 exactly 20 cycles after entering WAIT_RDY, cs=1. Repeat with ready asserted on the 20th cycle -> RX proceeds, rsp_err=0.
- rst asserted mid-TX (bit 6 of a write) -> next edge cs=1, sclk=0, no rsp_valid; req_ready=1 one cycle after rst drops; a new write completes normally.
- LSB_FIRST=0, write addr=0x05, din=0xA3 -> mosi 1,0,0,0,0,0,1,0,1,1,0,1,0,0,0,1,1; req_valid held high during the transaction is not re-accepted until after rsp_valid.

Source files
------------

// File: rtl/spi_mem_master.sv
// spi_mem_master: single-word SPI master for the serial memory path.
//   Host side : req_valid/req_ready handshake with req_wr, req_addr, req_din;
//               rsp_valid is a one-cycle pulse carrying rsp_err (0 ok,
//               1 address out of range, 2 timeout) and rsp_dout (read data).
//   Slave side: cs (active-low), sclk (mode 0, idles low), mosi, miso, plus
//               the slave's ready (read data available) and op_done (write
//               committed) status lines.
//   A frame is op bit, address, and (writes only) data, each field in the
//   LSB_FIRST order. One bit lasts 2*CLK_DIV clk cycles (low half, high half).
module spi_mem_master #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 32,
  parameter int CLK_DIV   = 1,
  parameter int LSB_FIRST = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_din,
  output logic              rsp_valid,
  output logic [1:0]        rsp_err,
  output logic [DATA_W-1:0] rsp_dout,
  output logic              cs,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  input  logic              ready,
  input  logic              op_done
);

  localparam int FW     = 1 + ADDR_W + DATA_W;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W  = $clog2(FW);
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [BIT_W-1:0]  WR_LAST   = BIT_W'(FW - 1);
  localparam logic [BIT_W-1:0]  RD_LAST   = BIT_W'(ADDR_W);
  localparam logic [BIT_W-1:0]  RX_LAST   = BIT_W'(DATA_W - 1);
  localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, CHECK, TX, WAIT_DONE, WAIT_RDY, RX, RESP} state_t;

  state_t              state_q, state_d;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   din_q;
  logic [FW-1:0]       frame_q;
  logic [DATA_W-1:0]   rx_q;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [WAIT_W-1:0]   wait_cnt;

  logic                accept, addr_bad, bit_end, wait_last;
  logic [BIT_W-1:0]    frame_last;
  logic [FW-1:0]       frame;

  // Reorder a field so that bit 0 is the first one on the wire.
  function automatic logic [ADDR_W-1:0] order_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = (LSB_FIRST != 0) ? a[i] : a[ADDR_W-1-i];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] order_data(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = (LSB_FIRST != 0) ? d[i] : d[DATA_W-1-i];
    return r;
  endfunction

  // Place one received bit so the word is complete after DATA_W samples.
  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] cur, input logic b);
    if (LSB_FIRST != 0) return {b, cur[DATA_W-1:1]};
    else                return {cur[DATA_W-2:0], b};
  endfunction

  assign accept     = req_valid && req_ready;
  assign addr_bad   = ({1'b0, addr_q} >= DEPTH_V);
  assign bit_end    = sclk && (div_cnt == DIV_LAST);
  assign wait_last  = (wait_cnt == WAIT_LAST);
  assign frame_last = wr_q ? WR_LAST : RD_LAST;
  // Transmission order: frame[0] goes out first. The data field is loaded
  // for reads too but the frame stops before reaching it.
  assign frame      = {order_data(din_q), order_addr(addr_q), wr_q};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = CHECK;
      CHECK:     state_d = addr_bad ? RESP : TX;
      TX:        if (bit_end && (bit_cnt == frame_last)) state_d = wr_q ? WAIT_DONE : WAIT_RDY;
      // The handshake is tested first so it wins over the final count.
      WAIT_DONE: if (op_done) state_d = RESP;
                 else if (wait_last) state_d = RESP;
      WAIT_RDY:  if (ready) state_d = RX;
                 else if (wait_last) state_d = RESP;
      RX:        if (bit_end && (bit_cnt == RX_LAST)) state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Request capture: payload registers carry no reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && accept) begin
      wr_q   <= req_wr;
      addr_q <= req_addr;
      din_q  <= req_din;
    end
  end

  // Serial engine and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 2'd0;
      rsp_dout  <= '0;
      cs        <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
    end else begin
      req_ready <= (state_d == IDLE);
      rsp_valid <= (state_d == RESP);
      case (state_q)
        CHECK: begin
          if (addr_bad) begin
            rsp_err <= 2'd1;
          end else begin
            cs      <= 1'b0;
            sclk    <= 1'b0;
            mosi    <= frame[0];
            frame_q <= frame;
            div_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        TX: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == frame_last) begin
                cs       <= 1'b1;
                mosi     <= 1'b0;
                wait_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
                frame_q <= frame_q >> 1;
                mosi    <= frame_q[1];
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        WAIT_DONE: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (op_done)        rsp_err <= 2'd0;
          else if (wait_last) rsp_err <= 2'd2;
        end
        WAIT_RDY: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (ready) begin
            cs      <= 1'b0;
            sclk    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
          end else if (wait_last) begin
            rsp_err <= 2'd2;
          end
        end
        RX: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
              rx_q <= rx_shift(rx_q, miso);
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == RX_LAST) begin
                cs       <= 1'b1;
                rsp_dout <= rx_q;
                rsp_err  <= 2'd0;
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master: two instances (LSB-first and MSB-first), both
// with ADDR_W=8, DATA_W=8, DEPTH=32, CLK_DIV=2, TIMEOUT=20. Stimulus pushes
// expected cs-low windows and responses into queues; monitors pop and compare.
module tb_spi_mem_master;
  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid [2];
  logic       req_ready [2];
  logic       req_wr    [2];
  logic [7:0] req_addr  [2];
  logic [7:0] req_din   [2];
  logic       rsp_valid [2];
  logic [1:0] rsp_err   [2];
  logic [7:0] rsp_dout  [2];
  logic       cs        [2];
  logic       sclk      [2];
  logic       mosi      [2];
  logic       miso      [2];
  logic       ready     [2];
  logic       op_done   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_mem_master #(
      .ADDR_W(8), .DATA_W(8), .DEPTH(32), .CLK_DIV(2),
      .LSB_FIRST(g == 0 ? 1 : 0), .TIMEOUT(TMO)
    ) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_wr(req_wr[g]),
      .req_addr(req_addr[g]), .req_din(req_din[g]),
      .rsp_valid(rsp_valid[g]), .rsp_err(rsp_err[g]), .rsp_dout(rsp_dout[g]),
      .cs(cs[g]), .sclk(sclk[g]), .mosi(mosi[g]), .miso(miso[g]),
      .ready(ready[g]), .op_done(op_done[g])
    );
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int d; int cyc; int err; int dout; } rsp_t;
  typedef struct { int d; int cyc; int n; logic [31:0] bits; } seg_t;

  rsp_t rsp_q[$];
  seg_t seg_q[$];
  int   tot = 0;
  int   bad = 0;
  int   dout_m [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor and cs-window monitor.
  bit          in_seg   [2];
  bit          seg_ab   [2];
  bit          prev_sclk[2];
  int          seg_c    [2];
  int          seg_n    [2];
  logic [31:0] seg_b    [2];
  rsp_t        mon_e;
  seg_t        mon_s;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rsp_valid[d] === 1'b1) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          mon_e = rsp_q.pop_front();
          check("rsp_dut", d, mon_e.d);
          check("rsp_cycle", cyc, mon_e.cyc);
          check("rsp_err", rsp_err[d], mon_e.err);
          check("rsp_dout", rsp_dout[d], mon_e.dout);
        end
      end
      if (cs[d] === 1'b0) begin
        if (!in_seg[d]) begin
          in_seg[d] = 1; seg_c[d] = 0; seg_n[d] = 0; seg_b[d] = '0; seg_ab[d] = 0;
        end
        if (rst) seg_ab[d] = 1;
        seg_c[d]++;
        if (sclk[d] && !prev_sclk[d] && seg_n[d] < 32) begin
          seg_b[d][seg_n[d]] = mosi[d];
          seg_n[d]++;
        end
      end else begin
        check("idle_sclk", sclk[d], 0);
        check("idle_mosi", mosi[d], 0);
        if (in_seg[d]) begin
          in_seg[d] = 0;
          if (!seg_ab[d]) begin
            if (seg_q.size() == 0) check("cs_unexpected", 1, 0);
            else begin
              mon_s = seg_q.pop_front();
              check("cs_dut", d, mon_s.d);
              check("cs_low_cycles", seg_c[d], mon_s.cyc);
              check("frame_nbits", seg_n[d], mon_s.n);
              check("frame_bits", seg_b[d], mon_s.bits);
            end
          end
        end
      end
      prev_sclk[d] = (sclk[d] === 1'b1);
    end
  end

  // One transaction. hs: index of the wait cycle carrying the slave handshake
  // (-1 = never). abort: assert rst during bit 6 of the frame.
  task automatic do_txn(input int d, input bit wr, input logic [7:0] addr, input logic [7:0] din,
                        input int hs, input logic [7:0] rx, input bit hold, input bit abort);
    int c0, w0, r0, a, nb, lastb, endc, n, k;
    bit lsb, oob, rxok;
    logic [31:0] bits;
    rsp_t e;
    seg_t s;
    lsb = (d == 0);
    req_valid[d] = 1'b1; req_wr[d] = wr; req_addr[d] = addr; req_din[d] = din;
    n = 0;
    @(negedge clk);
    while (!req_ready[d] && n < 10) begin n++; @(negedge clk); end
    check("accept_wait", n, 0);
    if (!req_ready[d]) begin req_valid[d] = 1'b0; return; end
    @(posedge clk); #1;
    c0 = cyc;
    if (!hold) req_valid[d] = 1'b0;

    oob  = (addr >= 8'd32);
    nb   = wr ? 17 : 9;
    w0   = c0 + 1 + 4 * nb;
    rxok = !oob && !wr && hs >= 0 && hs < TMO && !abort;
    r0   = w0 + hs + 1;
    a    = c0 + 1 + 4 * 6 + 1;
    bits = '0;
    bits[0] = wr;
    for (int i = 0; i < 8; i++) begin
      bits[1 + i] = lsb ? addr[i] : addr[7 - i];
      if (wr) bits[9 + i] = lsb ? din[i] : din[7 - i];
    end
    e.d = d;
    if (oob) begin
      e.err = 1; e.cyc = c0 + 1;
    end else if (hs >= 0 && hs < TMO) begin
      e.err = 0;
      e.cyc = wr ? (w0 + hs + 1) : (w0 + hs + 1 + 32);
    end else begin
      e.err = 2; e.cyc = w0 + TMO;
    end
    if (!abort) begin
      if (!oob) begin
        s.d = d; s.cyc = 4 * nb; s.n = nb; s.bits = bits; seg_q.push_back(s);
      end
      if (rxok) begin
        s.d = d; s.cyc = 32; s.n = 8; s.bits = '0; seg_q.push_back(s);
        dout_m[d] = rx;
      end
      e.dout = dout_m[d];
      rsp_q.push_back(e);
    end
    lastb = abort ? a + 2 : e.cyc;
    endc  = abort ? a + 3 : e.cyc;

    for (int cy = c0; cy <= endc; cy++) begin
      ready[d] = 1'b0; op_done[d] = 1'b0; miso[d] = 1'b0;
      if (cy == c0 + 3) begin ready[d] = 1'b1; op_done[d] = 1'b1; end
      if (!oob && !abort && hs >= 0 && cy == w0 + hs) begin
        if (wr) op_done[d] = 1'b1; else ready[d] = 1'b1;
      end
      if (rxok && cy >= r0 && cy < r0 + 32) begin
        k = (cy - r0) / 4;
        miso[d] = lsb ? rx[k] : rx[7 - k];
      end
      if (abort) rst = (cy >= a && cy < a + 2);
      @(negedge clk);
      check("busy_ready", req_ready[d], (cy > lastb) ? 1 : 0);
      if (abort && cy == a + 1) begin
        check("rst_cs", cs[d], 1);
        check("rst_sclk", sclk[d], 0);
        check("rst_mosi", mosi[d], 0);
        check("rst_rsp_valid", rsp_valid[d], 0);
      end
      @(posedge clk); #1;
    end
    ready[d] = 1'b0; op_done[d] = 1'b0; miso[d] = 1'b0;
    if (abort) begin dout_m[0] = 0; dout_m[1] = 0; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_wr[d] = 0; req_addr[d] = 0; req_din[d] = 0;
      miso[d] = 0; ready[d] = 0; op_done[d] = 0; dout_m[d] = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_req_ready", req_ready[d], 0);
      check("reset_rsp_valid", rsp_valid[d], 0);
      check("reset_rsp_err", rsp_err[d], 0);
      check("reset_rsp_dout", rsp_dout[d], 0);
      check("reset_cs", cs[d], 1);
      check("reset_sclk", sclk[d], 0);
      check("reset_mosi", mosi[d], 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst0", req_ready[0], 1);
    check("ready_after_rst1", req_ready[1], 1);

    // LSB-first write, then read with ready after 10 wait cycles.
    do_txn(0, 1, 8'h05, 8'hA3, 5, 8'h00, 0, 0);
    do_txn(0, 0, 8'h1F, 8'h00, 10, 8'h5C, 0, 0);
    // Out-of-range write and read leave rsp_dout alone.
    do_txn(0, 1, 8'h20, 8'h77, 3, 8'h00, 0, 0);
    do_txn(0, 0, 8'h20, 8'h00, 3, 8'hFF, 0, 0);
    // Timeout, then handshake on the final wait cycle.
    do_txn(0, 0, 8'h03, 8'h00, -1, 8'h00, 0, 0);
    do_txn(0, 0, 8'h03, 8'h00, TMO - 1, 8'h96, 0, 0);
    do_txn(0, 1, 8'h04, 8'h12, TMO, 8'h00, 0, 0);
    // Reset in the middle of a write, then a clean write.
    do_txn(0, 1, 8'h11, 8'h3C, -1, 8'h00, 0, 1);
    do_txn(0, 1, 8'h07, 8'h55, 0, 8'h00, 0, 0);
    // MSB-first write with req_valid held high across the transaction.
    do_txn(1, 1, 8'h05, 8'hA3, 2, 8'h00, 1, 0);
    do_txn(1, 1, 8'h05, 8'hA3, 3, 8'h00, 0, 0);
    do_txn(1, 0, 8'h1F, 8'h00, 7, 8'h5C, 0, 0);

    for (int i = 0; i < 24; i++) begin
      int          d;
      int          hs;
      logic [7:0]  ad;
      logic [7:0]  dn;
      logic [7:0]  rw;
      d  = $urandom_range(0, 1);
      ad = 8'($urandom_range(0, 40));
      dn = 8'($urandom);
      rw = 8'($urandom);
      hs = $urandom_range(0, 24);
      do_txn(d, 1'($urandom_range(0, 1)), ad, dn, hs, rw, 0, 0);
    end

    repeat (5) @(posedge clk);
    #1;
    check("rsp_queue_empty", rsp_q.size(), 0);
    check("cs_queue_empty", seg_q.size(), 0);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
